line_window_3x3: RTL and testbench



---
 rtl/line_window_3x3_pkg.sv | 14 +
 rtl/line_window_3x3_sdpram.sv | 30 +++
 rtl/line_window_3x3.sv | 164 ++++++++++++++++
 tb/tb_line_window_3x3.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/line_window_3x3_pkg.sv
// Shared video-pipeline defaults for the 3x3 line window and its line RAMs.
package line_window_3x3_pkg;

    localparam int VP_DATA_WIDTH     = 8;
    localparam int VP_IMG_HDISP      = 1280;
    localparam int VP_IMG_VDISP      = 720;
    localparam int VP_WINDOW_LATENCY = 2;

    typedef struct packed {
        logic vsync;
        logic href;
    } vp_sync_t;

endpackage

// File: rtl/line_window_3x3_sdpram.sv
// Simple dual-port line RAM: synchronous read-first, one-cycle read latency.
module vp_sdpram
    import line_window_3x3_pkg::*;
#(
    parameter int WIDTH      = VP_DATA_WIDTH,
    parameter int DEPTH      = VP_IMG_HDISP,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both accesses in one process so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_window_3x3.sv
// Builds a 3x3 pixel window from a raster stream using two line RAMs and
// three column shift registers; only fully-inside windows raise post_de.
module line_window_3x3
    import line_window_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = VP_DATA_WIDTH,
    parameter int IMG_HDISP  = VP_IMG_HDISP,
    parameter int IMG_VDISP  = VP_IMG_VDISP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  per_vsync,
    input  logic                  per_href,
    input  logic                  per_de,
    input  logic [DATA_WIDTH-1:0] per_data,
    output logic                  post_vsync,
    output logic                  post_href,
    output logic                  post_de,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33
);

    localparam int XW = $clog2(IMG_HDISP + 1);
    localparam int YW = $clog2(IMG_VDISP + 1);
    localparam int AW = $clog2(IMG_HDISP);
    localparam logic [XW-1:0] X_END = XW'(IMG_HDISP);
    localparam logic [YW-1:0] Y_END = YW'(IMG_VDISP);

    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    vp_sync_t              sync_pipe [VP_WINDOW_LATENCY];
    logic                  href_fall;
    logic                  vsync_rise;
    logic                  accept;
    logic                  win_ok;
    logic                  de_d1;
    logic                  ok_d1;
    logic [DATA_WIDTH-1:0] data_d1;
    logic [AW-1:0]         addr_d1;
    logic [DATA_WIDTH-1:0] row1_q;
    logic [DATA_WIDTH-1:0] row2_q;
    logic [DATA_WIDTH-1:0] win [3][3];

    assign href_fall  = sync_pipe[0].href & ~per_href;
    assign vsync_rise = per_vsync & ~sync_pipe[0].vsync;
    assign accept     = per_de & (x < X_END) & (y < Y_END);
    assign win_ok     = accept & (x >= XW'(2)) & (y >= YW'(2));

    // Counters saturate at the image size so overflow pixels/lines never alias into the RAMs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else begin
            if (href_fall) begin
                x <= '0;
            end else if (accept) begin
                x <= x + XW'(1);
            end
            if (vsync_rise) begin
                y <= '0;
            end else if (href_fall && (y < Y_END)) begin
                y <= y + YW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VP_WINDOW_LATENCY; i++) begin
                sync_pipe[i] <= '0;
            end
        end else begin
            sync_pipe[0] <= '{vsync: per_vsync, href: per_href};
            for (int i = 1; i < VP_WINDOW_LATENCY; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign post_vsync = sync_pipe[VP_WINDOW_LATENCY-1].vsync;
    assign post_href  = sync_pipe[VP_WINDOW_LATENCY-1].href;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d1   <= 1'b0;
            ok_d1   <= 1'b0;
            data_d1 <= '0;
            addr_d1 <= '0;
        end else begin
            de_d1   <= accept;
            ok_d1   <= win_ok;
            data_d1 <= per_data;
            addr_d1 <= x[AW-1:0];
        end
    end

    vp_sdpram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (IMG_HDISP)
    ) u_row1 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (x[AW-1:0]),
        .wr_data (per_data),
        .rd_en   (accept),
        .rd_addr (x[AW-1:0]),
        .rd_data (row1_q)
    );

    // Line y-1 migrates into the y-2 RAM one cycle after it is read out.
    vp_sdpram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (IMG_HDISP)
    ) u_row2 (
        .clk     (clk),
        .wr_en   (de_d1),
        .wr_addr (addr_d1),
        .wr_data (row1_q),
        .rd_en   (accept),
        .rd_addr (x[AW-1:0]),
        .rd_data (row2_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_de <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            post_de <= ok_d1;
            if (de_d1) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= row2_q;
                win[1][2] <= row1_q;
                win[2][2] <= data_d1;
            end
        end
    end

    assign matrix_p11 = win[0][0];
    assign matrix_p12 = win[0][1];
    assign matrix_p13 = win[0][2];
    assign matrix_p21 = win[1][0];
    assign matrix_p22 = win[1][1];
    assign matrix_p23 = win[1][2];
    assign matrix_p31 = win[2][0];
    assign matrix_p32 = win[2][1];
    assign matrix_p33 = win[2][2];

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3 on a small 8x6 image: frame scenario
// table, expected-window scoreboard, sync-delay tracking and a mid-line reset.
module tb_line_window_3x3;

    localparam int DW = 8;
    localparam int HD = 8;
    localparam int VD = 6;

    typedef struct {
        int npix;
        int nlines;
        int gapX;
        int gapLen;
        int vsLen;
        int expWindows;
    } scen_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          per_vsync;
    logic          per_href;
    logic          per_de;
    logic [DW-1:0] per_data;
    logic          post_vsync;
    logic          post_href;
    logic          post_de;
    logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;

    int            total = 0;
    int            bad = 0;
    int            winCount = 0;
    int            frameId = 0;
    logic [71:0]   expQ [$];
    logic [DW-1:0] img [8][10];
    logic          hv0 = 1'b0, hv1 = 1'b0, hh0 = 1'b0, hh1 = 1'b0;
    scen_t         scen [6];

    line_window_3x3 #(
        .DATA_WIDTH (DW),
        .IMG_HDISP  (HD),
        .IMG_VDISP  (VD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .per_vsync  (per_vsync),
        .per_href   (per_href),
        .per_de     (per_de),
        .per_data   (per_data),
        .post_vsync (post_vsync),
        .post_href  (post_href),
        .post_de    (post_de),
        .matrix_p11 (matrix_p11),
        .matrix_p12 (matrix_p12),
        .matrix_p13 (matrix_p13),
        .matrix_p21 (matrix_p21),
        .matrix_p22 (matrix_p22),
        .matrix_p23 (matrix_p23),
        .matrix_p31 (matrix_p31),
        .matrix_p32 (matrix_p32),
        .matrix_p33 (matrix_p33)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveCycle(input logic vs, input logic hr, input logic de, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        per_vsync = vs;
        per_href  = hr;
        per_de    = de;
        per_data  = d;
    endtask

    // Expected window for pixel (x,y): row 1 is line y-2, column 1 is x-2.
    task automatic pushPixel(input int x, input int y);
        if (x < HD && y < VD && x >= 2 && y >= 2) begin
            expQ.push_back({img[y-2][x-2], img[y-2][x-1], img[y-2][x],
                            img[y-1][x-2], img[y-1][x-1], img[y-1][x],
                            img[y][x-2],   img[y][x-1],   img[y][x]});
        end
    endtask

    // Drives one frame; stops early (href left high) at (abortX, abortLine) if abortLine >= 0.
    task automatic applyStimulus(input scen_t s, input int abortLine, input int abortX);
        logic [DW-1:0] key;
        logic [DW-1:0] v;
        frameId++;
        key = DW'(frameId * 37);
        for (int i = 0; i < s.vsLen; i++) driveCycle(1'b1, 1'b0, 1'b0, '0);
        driveCycle(1'b0, 1'b0, 1'b0, '0);
        for (int y = 0; y < s.nlines; y++) begin
            for (int x = 0; x < s.npix; x++) begin
                if (y == abortLine && x == abortX) return;
                if (x == s.gapX) begin
                    for (int g = 0; g < s.gapLen; g++) driveCycle(1'b0, 1'b1, 1'b0, 8'hEE);
                end
                v = DW'((y << 4) | x) ^ key;
                img[y][x] = v;
                driveCycle(1'b0, 1'b1, 1'b1, v);
                pushPixel(x, y);
            end
            repeat (3) driveCycle(1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    // Monitor: exact 2-cycle sync delay and in-order window scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            hv0 = 1'b0; hv1 = 1'b0; hh0 = 1'b0; hh1 = 1'b0;
        end else begin
            checkOutput("post_vsync_delay", {71'd0, post_vsync}, {71'd0, hv1});
            checkOutput("post_href_delay", {71'd0, post_href}, {71'd0, hh1});
            hv1 = hv0; hv0 = per_vsync;
            hh1 = hh0; hh0 = per_href;
            if (post_de) begin
                winCount++;
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL window_unexpected: got p11=%h p33=%h expected no window",
                             matrix_p11, matrix_p33);
                end else begin
                    checkOutput("window", {matrix_p11, matrix_p12, matrix_p13,
                                           matrix_p21, matrix_p22, matrix_p23,
                                           matrix_p31, matrix_p32, matrix_p33}, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        scen[0] = '{npix: 8,  nlines: 6, gapX: -1, gapLen: 0, vsLen: 3, expWindows: 24};
        scen[1] = '{npix: 10, nlines: 6, gapX: -1, gapLen: 0, vsLen: 2, expWindows: 24};
        scen[2] = '{npix: 8,  nlines: 6, gapX: 5,  gapLen: 3, vsLen: 2, expWindows: 24};
        scen[3] = '{npix: 8,  nlines: 8, gapX: -1, gapLen: 0, vsLen: 1, expWindows: 24};
        scen[4] = '{npix: 7,  nlines: 6, gapX: -1, gapLen: 0, vsLen: 1, expWindows: 20};
        scen[5] = '{npix: 8,  nlines: 2, gapX: -1, gapLen: 0, vsLen: 1, expWindows: 0};

        rst_n = 1'b0;
        per_vsync = 1'b0; per_href = 1'b0; per_de = 1'b0; per_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {45'd0, post_vsync, post_href, post_de,
                     matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                     matrix_p23, matrix_p31, matrix_p32, matrix_p33}, 72'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            winCount = 0;
            applyStimulus(scen[i], -1, 0);
            repeat (4) driveCycle(1'b0, 1'b0, 1'b0, '0);
            checkOutput($sformatf("scen%0d_window_count", i), 72'(winCount), 72'(scen[i].expWindows));
            checkOutput($sformatf("scen%0d_queue_drained", i), 72'(expQ.size()), 72'd0);
        end

        // Mid-line reset during line 4: outputs must drop at once, without a clock edge.
        applyStimulus(scen[0], 4, 4);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_href_active", {71'd0, post_href}, 72'd1);
        rst_n = 1'b0;
        per_href = 1'b0; per_de = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {45'd0, post_vsync, post_href, post_de,
                     matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                     matrix_p23, matrix_p31, matrix_p32, matrix_p33}, 72'd0);
        repeat (2) driveCycle(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        winCount = 0;
        applyStimulus(scen[0], -1, 0);
        repeat (4) driveCycle(1'b0, 1'b0, 1'b0, '0);
        checkOutput("post_reset_window_count", 72'(winCount), 72'd24);
        checkOutput("post_reset_queue_drained", 72'(expQ.size()), 72'd0);

        // Back-to-back frames with a single-cycle vsync and no extra blanking.
        winCount = 0;
        applyStimulus(scen[3], -1, 0);
        applyStimulus(scen[3], -1, 0);
        repeat (4) driveCycle(1'b0, 1'b0, 1'b0, '0);
        checkOutput("back_to_back_window_count", 72'(winCount), 72'd48);
        checkOutput("back_to_back_queue_drained", 72'(expQ.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
